result_watchdog: RTL and testbench

RESULT_WATCHDOG -- requirements
Module: result_watchdog

---
 rtl/result_watchdog.sv | 159 +++++++++++++++
 tb/tb_result_watchdog.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_watchdog.sv
// Result watchdog: after an arm pulse, waits for every result channel to
// report once. It captures the first value seen on each channel and compares
// it with the expected value latched at arm time. The run ends with pass or
// fail, or it ends with a timeout when the cycle budget runs out.
module result_watchdog #(
  parameter  int NCH     = 2,
  parameter  int DW      = 64,
  parameter  int TO_W    = 16,
  parameter  int TIMEOUT = 5000,
  localparam int IW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic [NCH*DW-1:0] exp_data,
  input  logic [NCH-1:0]    ready,
  input  logic [NCH*DW-1:0] result,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [NCH-1:0]    fail_mask,
  output logic [TO_W-1:0]   cycles,
  input  logic [IW-1:0]     rd_idx,
  output logic [DW-1:0]     rd_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [DW-1:0]     exp_q [NCH];
  logic [DW-1:0]     cap_q [NCH];
  logic [NCH-1:0]    seen_q;
  logic [NCH-1:0]    fail_q;
  logic [TO_W-1:0]   cnt_q;
  logic [TO_W-1:0]   cycles_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic              timeout_q;

  // Next-state terms for the WAIT state. A channel is captured only while
  // its seen bit is still clear. This makes the first ready cycle the only
  // one that counts, and a ready level already present when WAIT is
  // entered counts as that first cycle.
  logic [NCH-1:0]    new_cap_d;
  logic [NCH-1:0]    seen_d;
  logic [NCH-1:0]    mism_d;
  logic [NCH-1:0]    fail_d;
  logic              all_seen_d;
  logic              at_limit_d;
  logic [TO_W-1:0]   cnt_d;

  // Per-cycle capture, compare and counter arithmetic
  always_comb begin
    new_cap_d = ready & ~seen_q;
    seen_d    = seen_q | ready;
    mism_d    = '0;
    for (int i = 0; i < NCH; i++) begin
      mism_d[i] = new_cap_d[i] && (result[i*DW +: DW] != exp_q[i]);
    end
    fail_d     = fail_q | mism_d;
    all_seen_d = &seen_d;
    at_limit_d = (cnt_q == TO_W'(TIMEOUT - 1));
    cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  end

  // Run-control FSM with registered status outputs and capture storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      seen_q    <= '0;
      fail_q    <= '0;
      cnt_q     <= '0;
      cycles_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        exp_q[i] <= '0;
        cap_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state_q   <= S_WAIT;
            seen_q    <= '0;
            fail_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
              exp_q[i] <= exp_data[i*DW +: DW];
              cap_q[i] <= '0;
            end
          end
        end
        S_WAIT: begin
          // arm is deliberately not looked at here
          for (int i = 0; i < NCH; i++) begin
            if (new_cap_d[i]) begin
              cap_q[i] <= result[i*DW +: DW];
            end
          end
          seen_q <= seen_d;
          fail_q <= fail_d;
          cnt_q  <= cnt_d;
          // Captures are applied before the limit test, so a channel that
          // completes the set on the last allowed cycle still passes.
          if (all_seen_d) begin
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            pass_q    <= ~|fail_d;
            timeout_q <= 1'b0;
            cycles_q  <= cnt_d;
          end else if (at_limit_d) begin
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            pass_q    <= 1'b0;
            timeout_q <= 1'b1;
            fail_q    <= fail_d | ~seen_d;
            cycles_q  <= cnt_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Combinational capture-buffer read; indices past the last channel read 0
  always_comb begin
    rd_data = '0;
    if (int'(rd_idx) < NCH) begin
      rd_data = cap_q[rd_idx];
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign fail_mask = fail_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_result_watchdog.sv
// Bench for result_watchdog: table of complete runs checked through a
// scoreboard queue, plus hand-written sequences for arm-in-WAIT, repeated
// ready pulses and an asynchronous reset in the middle of a run.
module tb_result_watchdog;

  localparam int NCH     = 2;
  localparam int DW      = 32;
  localparam int TO_W    = 16;
  localparam int TIMEOUT = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              arm = 1'b0;
  logic [NCH*DW-1:0] exp_data = '0;
  logic [NCH-1:0]    ready = '0;
  logic [NCH*DW-1:0] result = '0;
  logic              busy, done, pass, timeout;
  logic [NCH-1:0]    fail_mask;
  logic [TO_W-1:0]   cycles;
  logic [0:0]        rd_idx = '0;
  logic [DW-1:0]     rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  result_watchdog #(
    .NCH(NCH), .DW(DW), .TO_W(TO_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .exp_data(exp_data),
    .ready(ready), .result(result), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .fail_mask(fail_mask),
    .cycles(cycles), .rd_idx(rd_idx), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // One run: expected/actual data, WAIT cycle index of each ready pulse
  // (-1 = never), and the expected outcome.
  typedef struct {
    logic [DW-1:0] e0, e1, r0, r1;
    int            c0, c1;
    logic          p, t;
    logic [1:0]    fm;
    int            cyc;
  } vec_t;

  vec_t vecs [8];
  vec_t sb [$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_pass"}, 64'(pass), 64'd0);
    chk({tag, "_timeout"}, 64'(timeout), 64'd0);
    chk({tag, "_fail_mask"}, 64'(fail_mask), 64'd0);
    chk({tag, "_cycles"}, 64'(cycles), 64'd0);
    rd_idx = 1'b0;
    #1;
    chk({tag, "_rd0"}, 64'(rd_data), 64'd0);
    rd_idx = 1'b1;
    #1;
    chk({tag, "_rd1"}, 64'(rd_data), 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    vec_t          e;
    int            k;
    logic [DW-1:0] want0, want1;
    exp_data = {v.e1, v.e0};
    arm = 1'b1;
    sb.push_back(v);
    tick();
    arm = 1'b0;
    exp_data = {~v.e1, ~v.e0};
    chk($sformatf("v%0d_arm_busy", id), 64'(busy), 64'd1);
    chk($sformatf("v%0d_arm_done", id), 64'(done), 64'd0);
    chk($sformatf("v%0d_arm_flags", id), 64'({pass, timeout, fail_mask}), 64'd0);
    k = 0;
    while (!done && k < 3 * TIMEOUT) begin
      ready[0] = (k == v.c0);
      ready[1] = (k == v.c1);
      result[DW-1:0]    = (k == v.c0) ? v.r0 : DW'($urandom);
      result[2*DW-1:DW] = (k == v.c1) ? v.r1 : DW'($urandom);
      tick();
      k++;
    end
    ready = '0;
    if (!done) begin
      chk($sformatf("v%0d_done_reached", id), 64'd0, 64'd1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      chk($sformatf("v%0d_scoreboard_entry", id), 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    want0 = (e.c0 >= 0) ? e.r0 : '0;
    want1 = (e.c1 >= 0) ? e.r1 : '0;
    // Flags and captures must survive further ready traffic in DONE
    for (int pass_n = 0; pass_n < 2; pass_n++) begin
      chk($sformatf("v%0d_%0d_busy", id, pass_n), 64'(busy), 64'd0);
      chk($sformatf("v%0d_%0d_done", id, pass_n), 64'(done), 64'd1);
      chk($sformatf("v%0d_%0d_pass", id, pass_n), 64'(pass), 64'(e.p));
      chk($sformatf("v%0d_%0d_timeout", id, pass_n), 64'(timeout), 64'(e.t));
      chk($sformatf("v%0d_%0d_fail_mask", id, pass_n), 64'(fail_mask), 64'(e.fm));
      chk($sformatf("v%0d_%0d_cycles", id, pass_n), 64'(cycles), 64'(e.cyc));
      rd_idx = 1'b0;
      #1;
      chk($sformatf("v%0d_%0d_rd0", id, pass_n), 64'(rd_data), 64'(want0));
      rd_idx = 1'b1;
      #1;
      chk($sformatf("v%0d_%0d_rd1", id, pass_n), 64'(rd_data), 64'(want1));
      if (pass_n == 0) begin
        ready  = 2'b11;
        result = {~e.r1, ~e.r0};
        tick();
        tick();
        ready = '0;
      end
    end
  endtask

  initial begin
    logic [DW-1:0] b0, b1;

    //               e0            e1            r0            r1            c0  c1  p     t     fm     cyc
    vecs[0] = '{32'h1111_0000, 32'h2222_0001, 32'h1111_0000, 32'h2222_0001,  3, 10, 1'b1, 1'b0, 2'b00, 11};
    vecs[1] = '{32'h0BAD_F00D, 32'hCAFE_0000, 32'h0BAD_F00D, 32'hCAFE_0001,  2,  5, 1'b0, 1'b0, 2'b10,  6};
    vecs[2] = '{32'h0000_0005, 32'h0000_0006, 32'h0000_0005, 32'h0000_0006,  4, -1, 1'b0, 1'b1, 2'b10, 20};
    vecs[3] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678,  0, 19, 1'b1, 1'b0, 2'b00, 20};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0000,  7,  7, 1'b0, 1'b0, 2'b01,  8};
    vecs[5] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0001, 32'h0000_0002, -1, -1, 1'b0, 1'b1, 2'b11, 20};
    vecs[6] = '{32'h0000_A5A5, 32'h0000_5A5A, 32'h0000_A5A4, 32'h0000_5A5A,  1, -1, 1'b0, 1'b1, 2'b11, 20};
    vecs[7] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 19,  0, 1'b1, 1'b0, 2'b00, 20};

    // Reset state
    tick();
    tick();
    chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
    end

    // Arm during WAIT is ignored; a second ready pulse on a seen channel
    // with different data does not replace the first capture.
    b0 = 32'h5555_1234;
    b1 = 32'h6666_4321;
    exp_data = {b1, b0};
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ready = '0;
      arm   = 1'b0;
      case (k)
        1: begin ready = 2'b01; result[DW-1:0] = b0; end
        2: begin arm = 1'b1; exp_data = {~b1, ~b0}; end
        3: begin ready = 2'b01; result[DW-1:0] = ~b0; end
        5: begin ready = 2'b10; result[2*DW-1:DW] = b1; end
        default: ;
      endcase
      tick();
      if (k == 2) begin
        chk("rearm_wait_busy", 64'(busy), 64'd1);
        chk("rearm_wait_done", 64'(done), 64'd0);
      end
    end
    ready = '0;
    arm   = 1'b0;
    chk("rearm_done", 64'(done), 64'd1);
    chk("rearm_pass", 64'(pass), 64'd1);
    chk("rearm_fail_mask", 64'(fail_mask), 64'd0);
    chk("rearm_cycles", 64'(cycles), 64'd6);
    rd_idx = 1'b0;
    #1;
    chk("rearm_rd0_first_capture", 64'(rd_data), 64'(b0));

    // Asynchronous reset in the middle of WAIT, then ready without arm
    exp_data = {32'hC1C1_C1C1, 32'hC0C0_C0C0};
    arm = 1'b1;
    tick();
    arm = 1'b0;
    ready = 2'b01;
    result[DW-1:0] = 32'hC0C0_C0C5;
    tick();
    ready = '0;
    tick();
    tick();
    chk("midrun_busy", 64'(busy), 64'd1);
    chk("midrun_fail_mask", 64'(fail_mask), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready = 2'b11;
    result = {32'hC1C1_C1C1, 32'hC0C0_C0C0};
    for (int k = 0; k < 6; k++) tick();
    ready = '0;
    chk("no_arm_busy", 64'(busy), 64'd0);
    chk("no_arm_done", 64'(done), 64'd0);
    rd_idx = 1'b0;
    #1;
    chk("no_arm_rd0", 64'(rd_data), 64'd0);

    // Normal operation resumes after a fresh arm
    run_vec(vecs[0], 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation still running, expected completion");
    $fatal(1, "time limit");
  end

endmodule
